// File: rtl/flt2int_arbiter_if.sv
// Requester and response handshake bundle for the shared float-to-int converter.
// The master side drives the requests and the response acknowledge; the slave side is the arbiter.
interface flt2int_arbiter_if;
   logic [1:0]  req_valid;
   logic [11:0] req_data0;
   logic [11:0] req_data1;
   logic [1:0]  req_ready;
   logic        resp_valid;
   logic        resp_id;
   logic [7:0]  resp_r;
   logic        resp_of;
   logic        resp_uf;
   logic        resp_ready;

   modport master (
      output req_valid, req_data0, req_data1, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_r, resp_of, resp_uf
   );

   modport slave (
      input  req_valid, req_data0, req_data1, resp_ready,
      output req_ready, resp_valid, resp_id, resp_r, resp_of, resp_uf
   );
endinterface

// File: rtl/flt2int_arbiter.sv
// Round-robin sharing of one 12-bit float to 8-bit sign-magnitude converter between two requesters,
// with saturating overflow/underflow event counters.
module flt2int_arbiter #(
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   flt2int_arbiter_if.slave   bus,
   input  logic               cnt_clr,
   output logic [CNT_W-1:0]   of_cnt,
   output logic [CNT_W-1:0]   uf_cnt
);

   typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [11:0]       op_q, op_d;
   logic              id_q, id_d;
   logic              resp_id_q, resp_id_d;
   logic [7:0]        resp_r_q, resp_r_d;
   logic              resp_of_q, resp_of_d;
   logic              resp_uf_q, resp_uf_d;
   logic [CNT_W-1:0]  of_cnt_q, of_cnt_d;
   logic [CNT_W-1:0]  uf_cnt_q, uf_cnt_d;

   logic [1:0]        grant;
   logic              hs;
   logic              hs_id;
   logic [3:0]        conv_e;
   logic [6:0]        conv_mag;
   logic              conv_of;
   logic              conv_uf;

   // A channel wins when it is alone, or when the other one was served last.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_grant
         assign grant[gi] = (state_q == IDLE) && bus.req_valid[gi] &&
                            (!bus.req_valid[1-gi] || (last_grant_q != 1'(gi)));
      end
   endgenerate

   assign hs    = |grant;
   assign hs_id = grant[1];

   // Exponent e keeps the top e fraction bits, i.e. a right shift by 7-e.
   always_comb begin
      conv_e   = op_q[10:7];
      conv_mag = 7'd0;
      conv_of  = 1'b0;
      conv_uf  = 1'b0;
      if (conv_e == 4'd0) begin
         conv_uf = 1'b1;
      end else if (conv_e >= 4'd8) begin
         conv_of = 1'b1;
      end else begin
         conv_mag = op_q[6:0] >> (4'd7 - conv_e);
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_d         = op_q;
      id_d         = id_q;
      resp_id_d    = resp_id_q;
      resp_r_d     = resp_r_q;
      resp_of_d    = resp_of_q;
      resp_uf_d    = resp_uf_q;
      of_cnt_d     = of_cnt_q;
      uf_cnt_d     = uf_cnt_q;

      case (state_q)
         IDLE: begin
            if (hs) begin
               op_d         = hs_id ? bus.req_data1 : bus.req_data0;
               id_d         = hs_id;
               last_grant_d = hs_id;
               state_d      = CONV;
            end
         end
         CONV: begin
            resp_id_d = id_q;
            resp_r_d  = {op_q[11], conv_mag};
            resp_of_d = conv_of;
            resp_uf_d = conv_uf;
            if (conv_of && !(&of_cnt_q)) of_cnt_d = of_cnt_q + 1'b1;
            if (conv_uf && !(&uf_cnt_q)) uf_cnt_d = uf_cnt_q + 1'b1;
            state_d   = RESP;
         end
         RESP: begin
            if (bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Clear wins over an increment landing in the same cycle.
      if (cnt_clr) begin
         of_cnt_d = '0;
         uf_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         op_q         <= 12'h000;
         id_q         <= 1'b0;
         resp_id_q    <= 1'b0;
         resp_r_q     <= 8'h00;
         resp_of_q    <= 1'b0;
         resp_uf_q    <= 1'b0;
         of_cnt_q     <= '0;
         uf_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_q         <= op_d;
         id_q         <= id_d;
         resp_id_q    <= resp_id_d;
         resp_r_q     <= resp_r_d;
         resp_of_q    <= resp_of_d;
         resp_uf_q    <= resp_uf_d;
         of_cnt_q     <= of_cnt_d;
         uf_cnt_q     <= uf_cnt_d;
      end
   end

   assign bus.req_ready  = grant;
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_r     = resp_r_q;
   assign bus.resp_of    = resp_of_q;
   assign bus.resp_uf    = resp_uf_q;
   assign of_cnt         = of_cnt_q;
   assign uf_cnt         = uf_cnt_q;

endmodule
